// File: rtl/nco_env_shaper_if.sv
// Signal bundle between the envelope shaper, its control source, the nco and the audio sink.
// The shaper uses the slave modport; whatever drives the controls and consumes samples uses master.
interface nco_env_shaper_if;
    logic        note_on;
    logic [7:0]  attack_inc;
    logic [7:0]  release_dec;
    logic [7:0]  sustain_lvl;
    logic        next_sample;
    logic [13:0] nco_code;
    logic [13:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  env_level;
    logic [1:0]  env_state;
    logic        overrun;

    modport master (
        output note_on, attack_inc, release_dec, sustain_lvl, nco_code, sample_ready,
        input  next_sample, sample, sample_valid, env_level, env_state, overrun
    );

    modport slave (
        input  note_on, attack_inc, release_dec, sustain_lvl, nco_code, sample_ready,
        output next_sample, sample, sample_valid, env_level, env_state, overrun
    );
endinterface

// File: rtl/nco_env_shaper.sv
// Sample-rate engine behind the nco: strobes the nco, captures its sine code, scales it by an
// attack/sustain/release envelope and offers the shaped sample to the sink over valid/ready.
module nco_env_shaper #(
    parameter int SAMPLE_DIV = 2500,
    parameter int MIDSCALE   = 8192
) (
    input  logic               clk,
    input  logic               rst,
    nco_env_shaper_if.slave    bus
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    // Sample-rate timing: strobe in cycle T, capture at the end of T+1, scale at the end of T+2.
    logic [DIV_W-1:0] div_q;
    logic             strobe;
    logic             capture_q;
    logic             scale_q;

    assign strobe = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            capture_q <= 1'b0;
            scale_q   <= 1'b0;
        end else begin
            div_q     <= strobe ? '0 : div_q + DIV_W'(1);
            capture_q <= strobe;
            scale_q   <= capture_q;
        end
    end

    assign bus.next_sample = strobe;

    // Envelope state machine: state register / next-state logic / outputs.
    env_state_t state_q;
    env_state_t state_d;
    logic [7:0] env_q;
    logic [7:0] env_d;
    logic [8:0] env_sum;
    logic [8:0] env_diff;

    // 9-bit intermediates make the saturation checks overflow- and wrap-free.
    assign env_sum  = {1'b0, env_q} + {1'b0, bus.attack_inc};
    assign env_diff = {1'b0, env_q} - {1'b0, bus.release_dec};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            env_q   <= '0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
        end
    end

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (capture_q) begin
            unique case (state_q)
                IDLE: begin
                    env_d = '0;
                    if (bus.note_on) state_d = ATTACK;
                end
                ATTACK: begin
                    if (!bus.note_on) begin
                        state_d = RELEASE;
                    end else if (env_sum >= {1'b0, bus.sustain_lvl}) begin
                        env_d   = bus.sustain_lvl;
                        state_d = SUSTAIN;
                    end else begin
                        env_d = env_sum[7:0];
                    end
                end
                SUSTAIN: begin
                    if (!bus.note_on) state_d = RELEASE;
                    else              env_d   = bus.sustain_lvl;
                end
                RELEASE: begin
                    if (bus.note_on) begin
                        // Retrigger resumes from the current level; above sustain it clamps straight away.
                        if (env_q > bus.sustain_lvl) begin
                            env_d   = bus.sustain_lvl;
                            state_d = SUSTAIN;
                        end else begin
                            state_d = ATTACK;
                        end
                    end else if (env_diff[8] || (env_diff == 9'd0)) begin
                        env_d   = '0;
                        state_d = IDLE;
                    end else begin
                        env_d = env_diff[7:0];
                    end
                end
                default: begin
                    state_d = IDLE;
                    env_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.env_state = state_q;
        bus.env_level = env_q;
    end

    // Capture stage: offset-removed sine code and the pre-update envelope.
    logic signed [14:0] s_q;
    logic        [8:0]  e_q;
    logic signed [14:0] s_d;

    assign s_d = signed'({1'b0, bus.nco_code} - 15'(MIDSCALE));

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
            e_q <= '0;
        end else if (capture_q) begin
            s_q <= s_d;
            e_q <= {1'b0, env_q};
        end
    end

    // Scale stage: e <= 255 keeps |p >>> 8| below 8192, so the sum always fits 14 bits.
    logic signed [23:0] prod;
    logic signed [23:0] prod_sh;
    logic signed [23:0] shaped;

    assign prod    = s_q * $signed(e_q);
    assign prod_sh = prod >>> 8;
    assign shaped  = prod_sh + $signed(24'(MIDSCALE));

    // Handshake: a transfer happens on any cycle with sample_valid && sample_ready. A load on
    // that same edge keeps valid high; a load while valid && !ready overwrites and sets overrun.
    logic [13:0] sample_q;
    logic        valid_q;
    logic        overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q  <= 14'(MIDSCALE);
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (scale_q) begin
            sample_q <= shaped[13:0];
            valid_q  <= 1'b1;
            if (valid_q && !bus.sample_ready) overrun_q <= 1'b1;
        end else if (valid_q && bus.sample_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.overrun      = overrun_q;

endmodule
